// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and fetch FSM state encoding for the MIPS32 core
package mips_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} fetch_state_t;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: instruction-memory request/response bus
interface pc_fetch_unit_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, single-outstanding imem fetch and IF/ID slot with redirect/stall
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pc_fetch_unit_if.master         imem,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  input  logic                    stall,
  output logic                    if_valid,
  output logic [31:0]             if_pc,
  output logic [31:0]             if_pc4,
  output logic [31:0]             if_instr,
  output logic                    misalign_err
);
  fetch_state_t state;
  logic [31:0] pc, pc4, hold_q;
  logic hs, rsp, free;
  assign pc4 = pc + 32'd4;
  assign hs = (state == REQ) && imem.req_ready;
  assign rsp = imem.rsp_valid;
  assign free = !if_valid || !stall;
  assign imem.req_valid = (state == REQ);
  assign imem.req_addr = pc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      hold_q <= NOP;
      if_valid <= 1'b0;
      if_pc <= 32'd0;
      if_pc4 <= 32'd0;
      if_instr <= NOP;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid && |redirect_pc[1:0];
      if (redirect_valid) begin
        pc <= {redirect_pc[31:2], 2'b00};
        if_valid <= 1'b0;
        // an accepted but unanswered request must have its response swallowed
        state <= ((state == REQ) && hs) || ((state inside {WAIT, DROP}) && !rsp) ? DROP : REQ;
      end else begin
        if (free) if_valid <= 1'b0;
        case (state)
          IDLE: state <= REQ;
          REQ: if (hs) state <= WAIT;
          WAIT: if (rsp) begin
            pc <= pc4;
            state <= free ? REQ : HOLD;
            if (free) {if_valid, if_pc, if_pc4, if_instr} <= {1'b1, pc, pc4, imem.rsp_data};
            else hold_q <= imem.rsp_data;
          end
          HOLD: if (free) begin
            {if_valid, if_pc, if_pc4, if_instr} <= {1'b1, pc - 32'd4, pc, hold_q};
            state <= REQ;
          end
          DROP: if (rsp) state <= REQ;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed per-cycle vector table plus reset/stale-response sequence
module tb_pc_fetch_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic redirect_valid = 1'b0, stall = 1'b0, if_valid, misalign_err;
  logic [31:0] redirect_pc = 32'd0, if_pc, if_pc4, if_instr, last_acc = 32'd0;
  int checks = 0, failures = 0;
  pc_fetch_unit_if bus();
  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem(bus),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_pc4(if_pc4), .if_instr(if_instr),
    .misalign_err(misalign_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic st, rdy, rsp, rv;
    logic [31:0] rpc;
    logic [130:0] exp;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic st, logic rdy, logic rsp, logic rv, logic [31:0] rpc,
                              logic rqv, logic [31:0] rqa, logic ifv, logic [31:0] ipc,
                              logic [31:0] ipc4, logic [31:0] ii, logic mis);
    vec_t v;
    v.st = st; v.rdy = rdy; v.rsp = rsp; v.rv = rv; v.rpc = rpc;
    v.exp = {rqv, rqa, ifv, ipc, ipc4, ii, mis};
    return v;
  endfunction
  function automatic logic [130:0] act();
    return {bus.req_valid, bus.req_addr, if_valid, if_pc, if_pc4, if_instr, misalign_err};
  endfunction
  task automatic check(input string nm, input logic [130:0] exp);
    logic [130:0] a;
    a = act();
    checks++;
    if (a !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, a, exp);
    end
  endtask
  task automatic run(input vec_t v, input string nm);
    stall = v.st; bus.req_ready = v.rdy; bus.rsp_valid = v.rsp;
    bus.rsp_data = 32'h2000_0000 + last_acc;
    redirect_valid = v.rv; redirect_pc = v.rpc;
    @(negedge clk);
    check(nm, v.exp);
    if (bus.req_valid && bus.req_ready) last_acc = bus.req_addr;
    @(posedge clk); #1;
  endtask
  localparam logic [130:0] RST = '0;
  initial begin
    bus.req_ready = 1'b1; bus.rsp_valid = 1'b0; bus.rsp_data = 32'd0;
    @(posedge clk); #1;
    check("reset", RST);
    rst_n = 1'b1;
    //            st rdy rsp rv rpc            rqv rqa            ifv if_pc          if_pc4       if_instr       mis
    tbl.push_back(mk(0,1,0,0,32'h0,          0,32'h0,          0,32'h0,       32'h0,       32'h0,         0));
    tbl.push_back(mk(0,1,0,0,32'h0,          1,32'h0,          0,32'h0,       32'h0,       32'h0,         0));
    tbl.push_back(mk(0,1,1,0,32'h0,          0,32'h0,          0,32'h0,       32'h0,       32'h0,         0));
    tbl.push_back(mk(0,1,0,0,32'h0,          1,32'h4,          1,32'h0,       32'h4,       32'h2000_0000, 0));
    tbl.push_back(mk(0,1,1,0,32'h0,          0,32'h4,          0,32'h0,       32'h4,       32'h2000_0000, 0));
    tbl.push_back(mk(1,1,0,0,32'h0,          1,32'h8,          1,32'h4,       32'h8,       32'h2000_0004, 0));
    tbl.push_back(mk(1,1,1,0,32'h0,          0,32'h8,          1,32'h4,       32'h8,       32'h2000_0004, 0));
    tbl.push_back(mk(1,1,0,0,32'h0,          0,32'hC,          1,32'h4,       32'h8,       32'h2000_0004, 0));
    tbl.push_back(mk(1,1,0,0,32'h0,          0,32'hC,          1,32'h4,       32'h8,       32'h2000_0004, 0));
    tbl.push_back(mk(1,1,0,0,32'h0,          0,32'hC,          1,32'h4,       32'h8,       32'h2000_0004, 0));
    tbl.push_back(mk(0,1,0,0,32'h0,          0,32'hC,          1,32'h4,       32'h8,       32'h2000_0004, 0));
    tbl.push_back(mk(0,1,0,0,32'h0,          1,32'hC,          1,32'h8,       32'hC,       32'h2000_0008, 0));
    tbl.push_back(mk(0,1,1,0,32'h0,          0,32'hC,          0,32'h8,       32'hC,       32'h2000_0008, 0));
    tbl.push_back(mk(0,1,0,0,32'h0,          1,32'h10,         1,32'hC,       32'h10,      32'h2000_000C, 0));
    tbl.push_back(mk(0,1,0,1,32'h100,        0,32'h10,         0,32'hC,       32'h10,      32'h2000_000C, 0));
    tbl.push_back(mk(0,1,1,0,32'h0,          0,32'h100,        0,32'hC,       32'h10,      32'h2000_000C, 0));
    tbl.push_back(mk(0,1,0,0,32'h0,          1,32'h100,        0,32'hC,       32'h10,      32'h2000_000C, 0));
    tbl.push_back(mk(0,1,1,0,32'h0,          0,32'h100,        0,32'hC,       32'h10,      32'h2000_000C, 0));
    tbl.push_back(mk(0,0,0,1,32'h202,        1,32'h104,        1,32'h100,     32'h104,     32'h2000_0100, 0));
    tbl.push_back(mk(0,0,0,0,32'h0,          1,32'h200,        0,32'h100,     32'h104,     32'h2000_0100, 1));
    tbl.push_back(mk(0,1,0,0,32'h0,          1,32'h200,        0,32'h100,     32'h104,     32'h2000_0100, 0));
    tbl.push_back(mk(0,1,1,0,32'h0,          0,32'h200,        0,32'h100,     32'h104,     32'h2000_0100, 0));
    tbl.push_back(mk(0,1,0,0,32'h0,          1,32'h204,        1,32'h200,     32'h204,     32'h2000_0200, 0));
    tbl.push_back(mk(0,1,1,1,32'hFFFF_FFFC,  0,32'h204,        0,32'h200,     32'h204,     32'h2000_0200, 0));
    tbl.push_back(mk(0,1,0,0,32'h0,          1,32'hFFFF_FFFC,  0,32'h200,     32'h204,     32'h2000_0200, 0));
    tbl.push_back(mk(0,1,1,0,32'h0,          0,32'hFFFF_FFFC,  0,32'h200,     32'h204,     32'h2000_0200, 0));
    tbl.push_back(mk(0,1,0,1,32'h40,         1,32'h0,          1,32'hFFFF_FFFC,32'h0,      32'h1FFF_FFFC, 0));
    tbl.push_back(mk(0,1,0,0,32'h0,          0,32'h40,         0,32'hFFFF_FFFC,32'h0,      32'h1FFF_FFFC, 0));
    tbl.push_back(mk(0,1,1,0,32'h0,          0,32'h40,         0,32'hFFFF_FFFC,32'h0,      32'h1FFF_FFFC, 0));
    tbl.push_back(mk(0,1,0,0,32'h0,          1,32'h40,         0,32'hFFFF_FFFC,32'h0,      32'h1FFF_FFFC, 0));
    tbl.push_back(mk(0,1,1,0,32'h0,          0,32'h40,         0,32'hFFFF_FFFC,32'h0,      32'h1FFF_FFFC, 0));
    tbl.push_back(mk(0,1,0,0,32'h0,          1,32'h44,         1,32'h40,      32'h44,      32'h2000_0040, 0));
    foreach (tbl[i]) run(tbl[i], $sformatf("row%0d", i + 1));
    // reset while the request for 0x44 is outstanding
    bus.rsp_valid = 1'b0; redirect_valid = 1'b0; rst_n = 1'b0;
    #1;
    check("async_reset", RST);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(mk(0,1,1,0,32'h0, 0,32'h0, 0,32'h0, 32'h0, 32'h0,         0), "stale_idle");
    run(mk(0,1,0,0,32'h0, 1,32'h0, 0,32'h0, 32'h0, 32'h0,         0), "restart_req");
    run(mk(0,1,1,0,32'h0, 0,32'h0, 0,32'h0, 32'h0, 32'h0,         0), "restart_wait");
    run(mk(0,1,0,0,32'h0, 1,32'h4, 1,32'h0, 32'h4, 32'h2000_0000, 0), "restart_if");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
